// File: rtl/odu_pkg.sv
// Shared types and constants for the ODU payload scheduler.
package odu_pkg;

   localparam int ODU_DATA_W = 384;
   // Channel id field is sized for the largest supported channel count (16).
   localparam int ODU_CHID_W = 4;
   // Burst counter holds up to 255 consecutive grants.
   localparam int ODU_CNT_W  = 8;

   // Ceiling log2 for elaboration-time width calculations.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } odu_state_t;

   typedef struct packed {
      logic [ODU_DATA_W-1:0] data;
      logic                  rs;
      logic [ODU_CHID_W-1:0] chid;
   } odu_word_t;

endpackage

// File: rtl/odu_rr_arb.sv
// Combinational round-robin picker: first eligible channel after 'last'.
module odu_rr_arb
   import odu_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int CHID_W = 2
) (
   input  logic [N_CH-1:0]   eligible,
   input  logic [CHID_W-1:0] last,
   output logic [CHID_W-1:0] grant,
   output logic              any_grant
);

   logic [2*N_CH-1:0] eligible_dbl;
   logic [CHID_W:0]   shamt;
   logic [N_CH-1:0]   rot;
   logic [N_CH:0]     below;
   logic [CHID_W-1:0] off_acc [N_CH+1];
   logic [CHID_W:0]   sum;

   // Rotate so that bit 0 of 'rot' is channel last+1; the doubled vector
   // makes the wrap-around free for any channel count.
   assign eligible_dbl = {eligible, eligible};
   assign shamt        = {1'b0, last} + (CHID_W+1)'(1);
   assign rot          = N_CH'(eligible_dbl >> shamt);

   // Find the lowest set bit of the rotated vector and encode its offset.
   assign below[0]   = 1'b0;
   assign off_acc[0] = '0;
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_pick
         assign below[gi+1]   = below[gi] | rot[gi];
         assign off_acc[gi+1] = off_acc[gi] |
                                ((rot[gi] & ~below[gi]) ? CHID_W'(gi) : '0);
      end
   endgenerate

   assign any_grant = below[N_CH];

   // Convert the offset back to a channel index modulo N_CH.
   assign sum   = {1'b0, last} + (CHID_W+1)'(1) + {1'b0, off_acc[N_CH]};
   assign grant = (sum >= (CHID_W+1)'(N_CH)) ? CHID_W'(sum - (CHID_W+1)'(N_CH))
                                              : CHID_W'(sum);

endmodule

// File: rtl/odu_payload_sched.sv
// Shares one payload-extraction datapath between N_CH channel word streams
// using round-robin arbitration with burst hold and a two-stage pipeline.
module odu_payload_sched
   import odu_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int DATA_W    = ODU_DATA_W,
   parameter int CHID_W    = clog2(N_CH),
   parameter int MAX_BURST = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_CH-1:0]        i_ch_en,
   input  logic [N_CH-1:0]        i_req_vld,
   input  logic [N_CH*DATA_W-1:0] i_req_data,
   input  logic [N_CH-1:0]        i_req_rs,
   output logic [N_CH-1:0]        o_req_rdy,
   output logic [DATA_W-1:0]      o_dp_data,
   output logic                   o_dp_rs,
   input  logic [DATA_W-1:0]      i_dp_payload,
   output logic                   o_out_vld,
   output logic [DATA_W-1:0]      o_out_data,
   output logic [CHID_W-1:0]      o_out_chid,
   input  logic                   i_out_rdy
);

   logic [N_CH-1:0]      eligible;
   logic                 stall;
   odu_state_t           state_reg, state_next;
   logic [CHID_W-1:0]    last_reg, last_next;
   logic [CHID_W-1:0]    cur_reg, cur_next;
   logic [ODU_CNT_W-1:0] cnt_reg, cnt_next;
   logic [CHID_W-1:0]    arb_grant;
   logic                 arb_any;
   logic [CHID_W-1:0]    grant_idx;
   logic                 grant_ok;
   logic [DATA_W-1:0]    req_words [N_CH];
   odu_word_t            s1_word;
   odu_word_t            s1_reg;
   logic                 s1_vld_reg;
   logic                 out_vld_reg;
   logic [DATA_W-1:0]    out_data_reg;
   logic [CHID_W-1:0]    out_chid_reg;
   logic                 unused_chid_hi;

   assign eligible = i_req_vld & i_ch_en;
   assign stall    = out_vld_reg & ~i_out_rdy;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign req_words[gi] = i_req_data[gi*DATA_W +: DATA_W];
         assign o_req_rdy[gi] = grant_ok & (grant_idx == CHID_W'(gi));
      end
   endgenerate

   odu_rr_arb #(
      .N_CH   (N_CH),
      .CHID_W (CHID_W)
   ) u_arb (
      .eligible  (eligible),
      .last      (last_reg),
      .grant     (arb_grant),
      .any_grant (arb_any)
   );

   // Grant selection and burst bookkeeping; a burst end always leaves one
   // idle cycle before the next arbitration.
   always_comb begin
      state_next = state_reg;
      last_next  = last_reg;
      cur_next   = cur_reg;
      cnt_next   = cnt_reg;
      grant_idx  = cur_reg;
      grant_ok   = 1'b0;
      case (state_reg)
         IDLE: begin
            grant_idx = arb_grant;
            grant_ok  = arb_any & ~stall & ~i_rst;
            if (grant_ok) begin
               state_next = BURST;
               cur_next   = arb_grant;
               cnt_next   = ODU_CNT_W'(1);
            end
         end
         BURST: begin
            grant_ok = (cnt_reg < ODU_CNT_W'(MAX_BURST)) & eligible[cur_reg] &
                       ~stall & ~i_rst;
            if (grant_ok) begin
               cnt_next = cnt_reg + ODU_CNT_W'(1);
            end
            if ((cnt_reg == ODU_CNT_W'(MAX_BURST)) || (!eligible[cur_reg] && !stall)) begin
               state_next = IDLE;
               last_next  = cur_reg;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Word presented to stage 1 when a grant is accepted.
   assign s1_word.data = ODU_DATA_W'(req_words[grant_idx]);
   assign s1_word.rs   = i_req_rs[grant_idx];
   assign s1_word.chid = ODU_CHID_W'(grant_idx);

   // Arbitration state register; ch0 gets first priority after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
         last_reg  <= CHID_W'(N_CH-1);
         cur_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
         cur_reg   <= cur_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Two-stage datapath: stage 1 feeds the extractor, stage 2 captures its
   // result. Both stages freeze together while the output is stalled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_reg       <= '0;
         s1_vld_reg   <= 1'b0;
         out_vld_reg  <= 1'b0;
         out_data_reg <= '0;
         out_chid_reg <= '0;
      end else if (!stall) begin
         s1_vld_reg  <= grant_ok;
         out_vld_reg <= s1_vld_reg;
         if (grant_ok) begin
            s1_reg <= s1_word;
         end
         if (s1_vld_reg) begin
            out_data_reg <= i_dp_payload;
            out_chid_reg <= CHID_W'(s1_reg.chid);
         end
      end
   end

   // Upper chid bits are zero-extension only.
   assign unused_chid_hi = ^(s1_reg.chid >> CHID_W);

   assign o_dp_data  = DATA_W'(s1_reg.data);
   assign o_dp_rs    = s1_reg.rs;
   assign o_out_vld  = out_vld_reg;
   assign o_out_data = out_data_reg;
   assign o_out_chid = out_chid_reg;

endmodule

// File: tb/tb_odu_payload_sched.sv
// Randomized self-checking bench for odu_payload_sched with a cycle-level
// reference model of the arbitration rules and an in-order scoreboard.
module tb_odu_payload_sched;

   localparam int N_CH   = 4;
   localparam int DATA_W = 384;
   localparam int CHID_W = 2;
   localparam int MB     = 3;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_CH-1:0]        ch_en, req_vld, req_rs, req_rdy;
   logic [N_CH*DATA_W-1:0] req_data;
   logic [DATA_W-1:0]      dp_data, dp_payload, out_data;
   logic                   dp_rs, out_vld, out_rdy;
   logic [CHID_W-1:0]      out_chid;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit                m_busy;
   int                m_last, m_cur, m_cnt;
   bit                m_s1_vld, m_out_vld;
   logic [DATA_W-1:0] q_data[$];
   int                q_ch[$];

   always #5 clk = ~clk;

   // Extractor stub: distinct transform per RS value.
   function automatic logic [DATA_W-1:0] stub(input logic [DATA_W-1:0] w, input logic rs);
      return rs ? {w[DATA_W-9:0], w[DATA_W-1:DATA_W-8]} : ~w;
   endfunction

   assign dp_payload = stub(dp_data, dp_rs);

   odu_payload_sched #(
      .N_CH      (N_CH),
      .DATA_W    (DATA_W),
      .CHID_W    (CHID_W),
      .MAX_BURST (MB)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_ch_en      (ch_en),
      .i_req_vld    (req_vld),
      .i_req_data   (req_data),
      .i_req_rs     (req_rs),
      .o_req_rdy    (req_rdy),
      .o_dp_data    (dp_data),
      .o_dp_rs      (dp_rs),
      .i_dp_payload (dp_payload),
      .o_out_vld    (out_vld),
      .o_out_data   (out_data),
      .o_out_chid   (out_chid),
      .i_out_rdy    (out_rdy)
   );

   task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int j = 0; j < DATA_W/32; j++) w[j*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic model_reset();
      m_busy    = 0;
      m_last    = N_CH-1;
      m_cur     = 0;
      m_cnt     = 0;
      m_s1_vld  = 0;
      m_out_vld = 0;
      q_data.delete();
      q_ch.delete();
   endtask

   // One clock cycle: drive inputs, check against the model, advance model.
   task automatic step(input bit rst_v, input logic [N_CH-1:0] en,
                       input logic [N_CH-1:0] vld, input bit rdy_v);
      logic [N_CH-1:0] elig, exp_rdy;
      bit              stl;
      int              g, c, cnt_old;
      @(negedge clk);
      rst     = rst_v;
      ch_en   = en;
      req_vld = vld;
      out_rdy = rdy_v;
      for (int k = 0; k < N_CH; k++) begin
         req_data[k*DATA_W +: DATA_W] = rand_word();
         req_rs[k] = 1'($urandom_range(0, 1));
      end
      #1;
      elig    = vld & en;
      stl     = m_out_vld && !rdy_v;
      g       = -1;
      exp_rdy = '0;
      if (!rst_v && !stl) begin
         if (!m_busy) begin
            for (int i = 1; i <= N_CH; i++) begin
               c = (m_last + i) % N_CH;
               if (elig[c]) begin
                  g = c;
                  break;
               end
            end
         end else if (m_cnt < MB && elig[m_cur]) begin
            g = m_cur;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_val("req_rdy", req_rdy, exp_rdy);
      check_val("out_vld", out_vld, m_out_vld);
      if (m_out_vld) begin
         if (q_data.size() == 0) begin
            check_val("sb_underflow", 1, 0);
         end else begin
            check_val("out_data", out_data, q_data[0]);
            check_val("out_chid", out_chid, q_ch[0]);
            if (rdy_v) begin
               $display("out ch=%0d data[31:0]=%h", out_chid, out_data[31:0]);
               void'(q_data.pop_front());
               void'(q_ch.pop_front());
            end
         end
      end
      @(posedge clk);
      if (rst_v) begin
         model_reset();
      end else begin
         if (!stl) begin
            m_out_vld = m_s1_vld;
            m_s1_vld  = (g >= 0);
         end
         if (g >= 0) begin
            q_data.push_back(stub(req_data[g*DATA_W +: DATA_W], req_rs[g]));
            q_ch.push_back(g);
         end
         cnt_old = m_cnt;
         if (!m_busy) begin
            if (g >= 0) begin
               m_busy = 1;
               m_cur  = g;
               m_cnt  = 1;
            end
         end else begin
            if (g >= 0) m_cnt++;
            if (cnt_old == MB || (!elig[m_cur] && !stl)) begin
               m_busy = 0;
               m_last = m_cur;
               m_cnt  = 0;
            end
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      ch_en    = '1;
      req_vld  = '1;
      req_rs   = '0;
      req_data = '0;
      out_rdy  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Reset state
      check_val("rst_req_rdy", req_rdy, 0);
      check_val("rst_out_vld", out_vld, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_out_chid", out_chid, 0);
      check_val("rst_dp_data", dp_data, 0);
      check_val("rst_dp_rs", dp_rs, 0);

      // Single channel stream on ch1
      for (int i = 0; i < 6; i++) step(0, 4'b1111, 4'b0010, 1);
      for (int i = 0; i < 4; i++) step(0, 4'b1111, 4'b0000, 1);
      // All channels continuously valid: rotation with idle gaps
      for (int i = 0; i < 20; i++) step(0, 4'b1111, 4'b1111, 1);
      // Backpressure mid-stream
      for (int i = 0; i < 5; i++) step(0, 4'b1111, 4'b1111, 0);
      for (int i = 0; i < 6; i++) step(0, 4'b1111, 4'b1111, 1);
      // Early burst end then a different channel
      for (int i = 0; i < 3; i++) step(0, 4'b1111, 4'b0100, 1);
      for (int i = 0; i < 5; i++) step(0, 4'b1111, 4'b1000, 1);
      // Disable a channel mid-burst
      for (int i = 0; i < 2; i++) step(0, 4'b1111, 4'b0011, 1);
      for (int i = 0; i < 5; i++) step(0, 4'b1110, 4'b0011, 1);
      // Reset mid-burst with words in flight, then check priority restart
      for (int i = 0; i < 3; i++) step(0, 4'b1111, 4'b1111, 1);
      step(1, 4'b1111, 4'b1111, 1);
      for (int i = 0; i < 4; i++) step(0, 4'b1111, 4'b1111, 1);
      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [N_CH-1:0] en_r;
         en_r = ($urandom_range(0, 9) == 0) ? ~N_CH'(1 << $urandom_range(0, N_CH-1))
                                            : '1;
         step($urandom_range(0, 299) == 0, en_r, N_CH'($urandom),
              $urandom_range(0, 3) != 0);
      end
      // Drain: everything accepted must have come out
      for (int i = 0; i < 8; i++) step(0, 4'b1111, 4'b0000, 1);
      check_val("drain_empty", q_data.size(), 0);
      check_val("drain_out_vld", out_vld, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
